// File: rtl/irq_arbiter.sv
// Machine-mode interrupt arbiter: picks the highest-priority eligible interrupt,
// offers it to the pipeline with a registered cause/target, and cools down after each ack.
module irq_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mip,
  input  logic [31:0] mie,
  input  logic        mstatus_mie,
  input  logic [31:0] mtvec,
  input  logic        irq_ack,
  output logic        irq_req,
  output logic [31:0] irq_cause,
  output logic [31:0] irq_target
);

  typedef enum logic [1:0] {IDLE, OFFER, COOL} state_e;

  // Bits 11,9,8,7,5,4,3,1,0 are the only implemented interrupt sources.
  localparam logic [31:0] IRQ_MASK = 32'h0000_0BBB;

  state_e      state_q;
  logic [3:0]  code_q;
  logic        req_q;
  logic [31:0] cause_q;
  logic [31:0] target_q;

  logic [31:0] eligible;
  logic        any_elig;
  logic [3:0]  sel_code;
  logic [31:0] cause_d;
  logic [31:0] target_d;

  function automatic logic [3:0] prio_code(input logic [31:0] e);
    if      (e[11]) prio_code = 4'd11;
    else if (e[3])  prio_code = 4'd3;
    else if (e[7])  prio_code = 4'd7;
    else if (e[9])  prio_code = 4'd9;
    else if (e[1])  prio_code = 4'd1;
    else if (e[5])  prio_code = 4'd5;
    else if (e[8])  prio_code = 4'd8;
    else if (e[0])  prio_code = 4'd0;
    else            prio_code = 4'd4;
  endfunction

  always_comb begin
    eligible = mip & mie & {32{mstatus_mie}} & IRQ_MASK;
    any_elig = |eligible;
    sel_code = prio_code(eligible);
    cause_d  = {1'b1, 27'b0, sel_code};
    target_d = {mtvec[31:2], 2'b00} +
               ((mtvec[1:0] == 2'b01) ? {26'b0, sel_code, 2'b00} : 32'b0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      code_q   <= 4'd0;
      req_q    <= 1'b0;
      cause_q  <= 32'h0;
      target_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_elig) begin
            state_q  <= OFFER;
            code_q   <= sel_code;
            cause_q  <= cause_d;
            target_q <= target_d;
            req_q    <= 1'b1;
          end
        end
        OFFER: begin
          // Ack wins over a simultaneous drop of the offered source.
          if (irq_ack) begin
            state_q <= COOL;
            req_q   <= 1'b0;
          end else if (!eligible[code_q]) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        end
        COOL: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req    = req_q;
  assign irq_cause  = cause_q;
  assign irq_target = target_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Randomized and directed bench for irq_arbiter against a behavioural offer/cooldown model.
module tb_irq_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mip, mie, mtvec;
  logic        mstatus_mie, irq_ack;
  logic        irq_req;
  logic [31:0] irq_cause, irq_target;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: offer flag, one-cycle cooldown flag, and the latched offer.
  bit          m_offering;
  bit          m_cooling;
  int          m_code;
  logic [31:0] m_cause, m_target;
  int          prio_list[9] = '{11, 3, 7, 9, 1, 5, 8, 0, 4};

  irq_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .mip        (mip),
    .mie        (mie),
    .mstatus_mie(mstatus_mie),
    .mtvec      (mtvec),
    .irq_ack    (irq_ack),
    .irq_req    (irq_req),
    .irq_cause  (irq_cause),
    .irq_target (irq_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_elig(input int b);
    return mip[b] && mie[b] && mstatus_mie;
  endfunction

  function automatic void model_reset();
    m_offering = 0;
    m_cooling  = 0;
    m_code     = 0;
    m_cause    = 32'h0;
    m_target   = 32'h0;
  endfunction

  function automatic void model_step();
    if (rst) begin
      model_reset();
    end else if (m_offering) begin
      if (irq_ack) begin
        m_offering = 0;
        m_cooling  = 1;
      end else if (!is_elig(m_code)) begin
        m_offering = 0;
      end
    end else if (m_cooling) begin
      m_cooling = 0;
    end else begin
      for (int k = 0; k < 9; k++) begin
        if (is_elig(prio_list[k])) begin
          m_code     = prio_list[k];
          m_offering = 1;
          m_cause    = 32'h8000_0000 + 32'(m_code);
          m_target   = (mtvec & ~32'h3) + ((mtvec % 4 == 1) ? 32'(m_code * 4) : 32'h0);
          break;
        end
      end
    end
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_req"},    {31'b0, irq_req}, {31'b0, m_offering});
    chk({tag, "_cause"},  irq_cause,  m_cause);
    chk({tag, "_target"}, irq_target, m_target);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic go_idle();
    mip = 32'h0;
    irq_ack = 1'b0;
    repeat (3) cycle("idle");
  endtask

  initial begin
    rst = 1'b1; mip = 0; mie = 0; mstatus_mie = 0; mtvec = 0; irq_ack = 0;
    model_reset();
    repeat (2) cycle("reset");
    rst = 1'b0;

    // Vectored MTI offer
    mie = 32'h888; mstatus_mie = 1'b1; mtvec = 32'h1000_0001; mip = 32'h080;
    cycle("v28");
    chk("v28_cause_k", irq_cause, 32'h8000_0007);
    chk("v28_target_k", irq_target, 32'h1000_001C);
    mtvec = 32'h3000_0001;
    cycle("v28_hold_mtvec");
    chk("v28_target_held", irq_target, 32'h1000_001C);

    // Direct mode MEI, ack, cooldown, re-offer
    go_idle();
    mip = 32'h888; mtvec = 32'h2000_0000;
    cycle("v29_offer");
    chk("v29_cause_k", irq_cause, 32'h8000_000B);
    chk("v29_target_k", irq_target, 32'h2000_0000);
    irq_ack = 1'b1;
    cycle("v29_cool");
    chk("v29_cool_req", {31'b0, irq_req}, 32'h0);
    irq_ack = 1'b0;
    cycle("v29_idle");
    cycle("v29_reoffer");
    chk("v29_reoffer_req", {31'b0, irq_req}, 32'h1);

    // No preemption by a higher-priority arrival
    go_idle();
    mip = 32'h080;
    cycle("v30_offer");
    mip = 32'h880;
    repeat (2) cycle("v30_nopreempt");
    chk("v30_cause_k", irq_cause, 32'h8000_0007);
    irq_ack = 1'b1;
    cycle("v30_cool");
    irq_ack = 1'b0;
    cycle("v30_idle");
    cycle("v30_next");
    chk("v30_next_k", irq_cause, 32'h8000_000B);

    // Withdraw vs ack-wins
    go_idle();
    mip = 32'h008;
    cycle("v31_offer");
    mip = 32'h0;
    cycle("v31_withdraw");
    mip = 32'h008;
    cycle("v31_reoffer_now");
    chk("v31_after_withdraw_req", {31'b0, irq_req}, 32'h1);
    mip = 32'h0; irq_ack = 1'b1;
    cycle("v31_ackwins");
    mip = 32'h008; irq_ack = 1'b0;
    cycle("v31_cool_blocks");
    chk("v31_cool_req", {31'b0, irq_req}, 32'h0);
    cycle("v31_after_cool");

    // Global disable
    go_idle();
    mstatus_mie = 1'b0; mip = 32'hFFFF_FFFF; mie = 32'hFFFF_FFFF;
    repeat (20) cycle("v32_gdis");
    mstatus_mie = 1'b1;
    cycle("v32_enable");

    // Async reset between edges while offering
    go_idle();
    mie = 32'h888; mip = 32'h080; mtvec = 32'h1000_0001;
    cycle("v33_offer");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_model("v33_async");
    cycle("v33_held");
    rst = 1'b0;
    cycle("v33_first_arb");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) mip = $urandom & $urandom;
      if ($urandom_range(0, 15) == 0) mie = $urandom | $urandom;
      if ($urandom_range(0, 15) == 0) mstatus_mie = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 7) == 0) mtvec = $urandom;
      irq_ack = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 199) == 0);
      cycle("rnd");
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL clear immediately when rst rises, independent of clk.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 mip  input  32  machine interrupt-pending register value; only bits 11,9,8,7,5,4,3,1,0 are meaningful, all other bits are ignored.
REQ-005 mie  input  32  machine interrupt-enable register value, with the same bit layout as mip.
REQ-006 mstatus_mie  input  1  global machine interrupt enable.
REQ-007 mtvec  input  32  trap vector base; [1:0]=01 selects vectored mode, any other value selects direct mode.
REQ-008 irq_ack  input  1  pipeline has committed the trap for the currently offered interrupt this cycle.
REQ-009 irq_req  output  1  registered interrupt request to the pipeline.
REQ-010 irq_cause  output  32  registered mcause value for the offered interrupt.
REQ-011 irq_target  output  32  registered trap handler PC for the offered interrupt.

Function
REQ-012 eligible[i] SHALL be mip[i] & mie[i] & mstatus_mie for each i in {11,9,8,7,5,4,3,1,0}.
REQ-013 Selection priority SHALL be, highest first: 11 (MEI), 3 (MSI), 7 (MTI), 9 (SEI), 1 (SSI), 5 (STI), 8 (UEI), 0 (USI), 4 (UTI).
REQ-014 irq_cause SHALL be {1'b1, 27'b0, code[3:0]}, where code is the selected bit index.
REQ-015 irq_target SHALL be {mtvec[31:2],2'b00} + (code<<2) in vectored mode, or {mtvec[31:2],2'b00} in direct mode; the 32-bit sum SHALL wrap modulo 2^32.
REQ-016 The FSM SHALL have three states: IDLE, OFFER and COOL.
- IDLE: if any bit is eligible, latch code and compute target, then go to OFFER; otherwise remain in IDLE.
- OFFER: irq_req=1, with irq_cause and irq_target held constant.
- COOL: irq_req=0 for exactly one cycle, then go to IDLE.
REQ-017 Latency: an eligible bit sampled in IDLE on edge N SHALL produce irq_req=1 after edge N, i.e. one cycle of latency.
REQ-018 In OFFER, irq_ack=1 SHALL cause the next state to be COOL.
REQ-019 In OFFER, if irq_ack=0 and eligible[code] has dropped, the block SHALL withdraw: the next state is IDLE and irq_req=0.
REQ-020 If irq_ack and a drop of eligible[code] occur in the same cycle, irq_ack SHALL win and the next state SHALL be COOL.
REQ-021 No preemption: a higher-priority bit that becomes eligible while in OFFER SHALL NOT change irq_cause or irq_target; it is arbitrated in the next IDLE.
REQ-022 Changes to mtvec while in OFFER SHALL NOT change irq_target.
REQ-023 irq_ack while in IDLE or COOL SHALL be ignored.
REQ-024 irq_req SHALL never be 1 on two consecutive cycles spanning two different offers; COOL or IDLE always separates them.

Reset
REQ-025 On reset the state SHALL be IDLE, with irq_req=0, irq_cause=32'h0 and irq_target=32'h0.
REQ-026 Reset asserted in OFFER SHALL drop irq_req asynchronously, and no ack SHALL be expected afterwards.
REQ-027 After rst falls, the first arbitration SHALL occur on the first clk edge that samples rst=0.

Verification
REQ-028 mie=0x888, mstatus_mie=1, mtvec=0x1000_0001, mip=0x080 -> after 1 edge: irq_req=1, irq_cause=0x8000_0007, irq_target=0x1000_001C.
REQ-029 mip=0x888, mtvec=0x2000_0000 -> irq_cause=0x8000_000B, irq_target=0x2000_0000; irq_ack for 1 cycle -> irq_req=0 for 1 COOL cycle, then re-offer of 0x8000_000B while mip is still set.
REQ-030 In OFFER with cause 7, set mip bit 11 -> irq_cause remains 0x8000_0007 until ack; after COOL, the next offer is 0x8000_000B.
REQ-031 In OFFER with cause 3, clear mip[3] with irq_ack=0 -> irq_req=0 next cycle, state IDLE; repeat with irq_ack=1 in the same cycle -> COOL, acknowledged.
REQ-032 mstatus_mie=0 with all mip and mie bits set -> irq_req stays 0 for 20 cycles.
REQ-033 Assert rst mid-OFFER, between edges -> irq_req, irq_cause and irq_target all read 0 before the next edge.
